keyb_report_seq: RTL and testbench

//  Sequences USB HID boot-keyboard reports through the combinational keymap

---
 rtl/keyb_report_seq.sv | 182 ++++++++++++++++++
 tb/tb_keyb_report_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keyb_report_seq.sv
// HID boot-keyboard report sequencer: finds newly pressed keys, walks them through
// the external keymap one at a time and streams the characters, with typematic repeat.
module keyb_report_seq #(
    parameter int unsigned REPEAT_DELAY  = 13_500_000,
    parameter int unsigned REPEAT_PERIOD = 900_000,
    parameter int unsigned CNT_W         = 24,
    parameter bit          NULLIFY       = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_report,
    input  logic        i_report_valid,
    output logic        o_report_ready,
    output logic        o_drop,
    output logic [7:0]  o_km_byte,
    output logic [7:0]  o_km_mod,
    output logic        o_km_nullify,
    input  logic [7:0]  i_km_char,
    output logic [7:0]  o_char,
    output logic        o_char_valid,
    input  logic        i_char_ready
);

    typedef enum logic [2:0] {
        IDLE, SCAN, LOOKUP, EMIT, DONE, RPT_LOOKUP, RPT_EMIT
    } state_e;

    state_e                state_q, state_d;
    logic [2:0]            slot_q, slot_d;
    logic [7:0]            mod_q, mod_d;
    logic [5:0][7:0]       keys_q, keys_d;
    logic [5:0][7:0]       prev_q, prev_d;
    logic [7:0]            rpt_key_q, rpt_key_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            km_byte_q, km_byte_d;
    logic [7:0]            km_mod_q, km_mod_d;
    logic [7:0]            char_q, char_d;

    logic       phantom, in_prev, rpt_present, last_slot;
    logic [7:0] cur_key;
    logic       unused_rsvd;

    assign unused_rsvd = ^i_report[15:8];
    assign cur_key     = keys_q[slot_q];
    assign last_slot   = (slot_q == 3'd5);

    always_comb begin
        phantom     = 1'b1;
        in_prev     = 1'b0;
        rpt_present = 1'b0;
        for (int i = 0; i < 6; i++) begin
            phantom     = phantom & (i_report[16+8*i +: 8] == 8'h01);
            in_prev     = in_prev | (prev_q[i] == cur_key);
            rpt_present = rpt_present | (keys_q[i] == rpt_key_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        mod_d     = mod_q;
        keys_d    = keys_q;
        prev_d    = prev_q;
        rpt_key_d = rpt_key_q;
        km_byte_d = km_byte_q;
        km_mod_d  = km_mod_q;
        char_d    = char_q;
        // Repeat timer free-runs whenever a key is armed; loads below override it.
        cnt_d     = (rpt_key_q != 8'h00 && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;

        unique case (state_q)
            IDLE: begin
                if (i_report_valid) begin
                    if (!phantom) begin
                        mod_d   = i_report[7:0];
                        keys_d  = i_report[63:16];
                        slot_d  = 3'd0;
                        state_d = SCAN;
                    end
                end else if (rpt_key_q != 8'h00 && cnt_q == '0) begin
                    km_byte_d = rpt_key_q;
                    km_mod_d  = mod_q;
                    state_d   = RPT_LOOKUP;
                end
            end
            SCAN: begin
                if (cur_key >= 8'h04 && !in_prev) begin
                    km_byte_d = cur_key;
                    km_mod_d  = mod_q;
                    state_d   = LOOKUP;
                end else if (last_slot) begin
                    state_d = DONE;
                end else begin
                    slot_d  = slot_q + 3'd1;
                    state_d = SCAN;
                end
            end
            LOOKUP: begin
                char_d = i_km_char;
                if (i_km_char != 8'h00) begin
                    rpt_key_d = cur_key;
                    cnt_d     = CNT_W'(REPEAT_DELAY);
                    state_d   = EMIT;
                end else if (last_slot) begin
                    state_d = DONE;
                end else begin
                    slot_d  = slot_q + 3'd1;
                    state_d = SCAN;
                end
            end
            EMIT: begin
                if (i_char_ready) begin
                    if (last_slot) begin
                        state_d = DONE;
                    end else begin
                        slot_d  = slot_q + 3'd1;
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                prev_d = keys_q;
                if (!rpt_present) begin
                    rpt_key_d = 8'h00;
                    cnt_d     = '0;
                end
                state_d = IDLE;
            end
            RPT_LOOKUP: begin
                char_d = i_km_char;
                if (i_km_char != 8'h00) begin
                    state_d = RPT_EMIT;
                end else begin
                    cnt_d   = CNT_W'(REPEAT_PERIOD);
                    state_d = IDLE;
                end
            end
            RPT_EMIT: begin
                if (i_char_ready) begin
                    cnt_d   = CNT_W'(REPEAT_PERIOD);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            slot_q    <= 3'd0;
            mod_q     <= 8'h00;
            keys_q    <= '0;
            prev_q    <= '0;
            rpt_key_q <= 8'h00;
            cnt_q     <= '0;
            km_byte_q <= 8'h00;
            km_mod_q  <= 8'h00;
            char_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            mod_q     <= mod_d;
            keys_q    <= keys_d;
            prev_q    <= prev_d;
            rpt_key_q <= rpt_key_d;
            cnt_q     <= cnt_d;
            km_byte_q <= km_byte_d;
            km_mod_q  <= km_mod_d;
            char_q    <= char_d;
        end
    end

    assign o_report_ready = (state_q == IDLE);
    assign o_drop         = i_report_valid & ~o_report_ready;
    assign o_km_byte      = km_byte_q;
    assign o_km_mod       = km_mod_q;
    assign o_km_nullify   = NULLIFY;
    assign o_char         = char_q;
    assign o_char_valid   = (state_q == EMIT) || (state_q == RPT_EMIT);

endmodule

// File: tb/tb_keyb_report_seq.sv
// Bench for keyb_report_seq: behavioural keymap plus a report-level model of
// which characters each report should produce; directed cases then random reports.
module tb_keyb_report_seq;

    localparam int DLY = 10;
    localparam int PER = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] report;
    logic        report_valid;
    logic        ready, drop, nullify, cv, char_ready;
    logic [7:0]  km_byte, km_mod, km_char, ch;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [7:0] prev [6];
    logic [7:0] exp_q [$];
    logic [7:0] obs_q [$];
    int         first_n;
    int         t_first;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keyb_report_seq #(.REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .CNT_W(24), .NULLIFY(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_report(report), .i_report_valid(report_valid),
        .o_report_ready(ready), .o_drop(drop), .o_km_byte(km_byte), .o_km_mod(km_mod),
        .o_km_nullify(nullify), .i_km_char(km_char), .o_char(ch), .o_char_valid(cv),
        .i_char_ready(char_ready)
    );

    // US boot keymap subset: letters, digits; Ctrl gives control codes, Shift uppercase.
    function automatic logic [7:0] km(input logic [7:0] code, input logic [7:0] mod, input logic nul);
        logic shift, ctrl;
        shift = mod[1] | mod[5];
        ctrl  = mod[0] | mod[4];
        if (code >= 8'h04 && code <= 8'h1D) begin
            if (ctrl)       return code - 8'h04 + 8'h01;
            else if (shift) return code - 8'h04 + 8'h41;
            else            return code - 8'h04 + 8'h61;
        end
        if (code >= 8'h1E && code <= 8'h26) return code - 8'h1E + 8'h31;
        if (code == 8'h27) return 8'h30;
        return nul ? 8'h00 : 8'h3F;
    endfunction

    always_comb km_char = km(km_byte, km_mod, nullify);

    function automatic logic [63:0] rep6(input logic [7:0] mod, input logic [7:0] k0, k1, k2, k3, k4, k5);
        return {k5, k4, k3, k2, k1, k0, 8'h00, mod};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected characters of one accepted report: each slot holding a real key
    // that was not down in the previous report, translated, nulls skipped.
    task automatic model(input logic [63:0] rep);
        bit ph;
        logic [7:0] k;
        bit seen;
        exp_q.delete();
        ph = 1'b1;
        for (int s = 0; s < 6; s++) if (rep[16+8*s +: 8] != 8'h01) ph = 1'b0;
        if (ph) return;
        for (int s = 0; s < 6; s++) begin
            k = rep[16+8*s +: 8];
            seen = 1'b0;
            for (int j = 0; j < 6; j++) if (prev[j] == k) seen = 1'b1;
            if (k >= 8'h04 && !seen && km(k, rep[7:0], 1'b1) != 8'h00)
                exp_q.push_back(km(k, rep[7:0], 1'b1));
        end
        for (int s = 0; s < 6; s++) prev[s] = rep[16+8*s +: 8];
    endtask

    task automatic send(input logic [63:0] rep);
        int n;
        n = 0;
        while (!ready && n < 100) begin @(negedge clk); n++; end
        if (!ready) chk("send_timeout", 32'(ready), 32'd1);
        report = rep;
        report_valid = 1'b1;
        @(posedge clk);
        #1 report_valid = 1'b0;
    endtask

    task automatic collect(input bit rnd_rdy);
        bit done;
        done = 1'b0;
        obs_q.delete();
        first_n = -1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            char_ready = rnd_rdy ? 1'($urandom % 2) : 1'b1;
            if (cv && char_ready) begin
                if (first_n < 0) begin first_n = n; t_first = cyc; end
                obs_q.push_back(ch);
            end
            if (ready) begin done = 1'b1; break; end
        end
        if (!done) chk("collect_timeout", 32'(ready), 32'd1);
        char_ready = 1'b1;
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk({tag, "_char"}, 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    task automatic run(input logic [63:0] rep, input bit rnd_rdy, input string tag);
        model(rep);
        send(rep);
        collect(rnd_rdy);
        compare(tag);
    endtask

    initial begin
        int t[4];
        int nrep, nv;
        logic [63:0] a, b;
        logic [7:0] c0;
        rst_n = 1'b0; report = '0; report_valid = 1'b0; char_ready = 1'b1;
        for (int s = 0; s < 6; s++) prev[s] = 8'h00;
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_cvalid", 32'(cv), 32'd0);
        chk("rst_char", 32'(ch), 32'd0);
        chk("rst_kmbyte", 32'(km_byte), 32'd0);
        chk("rst_kmmod", 32'(km_mod), 32'd0);
        chk("rst_nullify", 32'(nullify), 32'd1);
        chk("rst_drop", 32'(drop), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // single key, latency T+3
        run(rep6(8'h00, 8'h04, 0, 0, 0, 0, 0), 1'b0, "t1");
        chk("t1_latency", 32'(first_n), 32'd3);
        chk("t1_ready_back", 32'(ready), 32'd1);
        run(64'h0, 1'b0, "t1_rel");

        // two keys with shift, then the same report again
        run(rep6(8'h02, 8'h0B, 8'h08, 0, 0, 0, 0), 1'b0, "t2");
        run(rep6(8'h02, 8'h0B, 8'h08, 0, 0, 0, 0), 1'b0, "t2_same");
        run(64'h0, 1'b0, "t2_rel");

        // sink stall with a dropped report in the middle
        model(rep6(8'h00, 8'h04, 0, 0, 0, 0, 0));
        char_ready = 1'b0;
        send(rep6(8'h00, 8'h04, 0, 0, 0, 0, 0));
        nv = 0;
        while (!cv && nv < 10) begin @(negedge clk); nv++; end
        chk("t3_valid_seen", 32'(cv), 32'd1);
        c0 = ch;
        chk("t3_char", 32'(c0), 32'h61);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 10) begin
                report = rep6(8'h00, 8'h05, 0, 0, 0, 0, 0);
                report_valid = 1'b1;
                #1 chk("t3_drop", 32'(drop), 32'd1);
                @(posedge clk);
                #1 report_valid = 1'b0;
            end else begin
                chk("t3_hold_valid", 32'(cv), 32'd1);
                chk("t3_hold_char", 32'(ch), 32'(c0));
            end
        end
        collect(1'b0);
        compare("t3");
        run(64'h0, 1'b0, "t3_rel");

        // typematic repeat timing, then release stops it
        run(rep6(8'h00, 8'h1E, 0, 0, 0, 0, 0), 1'b0, "t4");
        t[0] = t_first;
        nrep = 1;
        for (int i = 0; i < 80 && nrep < 4; i++) begin
            @(negedge clk);
            if (cv) begin
                chk("t4_rpt_char", 32'(ch), 32'h31);
                t[nrep] = cyc;
                nrep++;
            end
        end
        chk("t4_rpt_count", 32'(nrep), 32'd4);
        chk("t4_first_gap", 32'(t[1] - t[0]), 32'(DLY + 2));
        chk("t4_gap1", 32'(t[2] - t[1]), 32'(PER + 3));
        chk("t4_gap2", 32'(t[3] - t[2]), 32'(PER + 3));
        run(64'h0, 1'b0, "t4_rel");
        nv = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (cv) nv++; end
        chk("t4_no_rpt", 32'(nv), 32'd0);

        // phantom report leaves history intact
        run(rep6(8'h00, 8'h04, 0, 0, 0, 0, 0), 1'b0, "t5");
        run(rep6(8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 1'b0, "t5_ph");
        run(rep6(8'h00, 8'h04, 0, 0, 0, 0, 0), 1'b0, "t5_held");
        run(64'h0, 1'b0, "t5_rel");

        // ctrl, unmapped key, reset during EMIT
        run(rep6(8'h01, 8'h06, 0, 0, 0, 0, 0), 1'b0, "t6_ctrl");
        run(rep6(8'h00, 8'h3A, 0, 0, 0, 0, 0), 1'b0, "t6_f1");
        run(64'h0, 1'b0, "t6_rel");
        char_ready = 1'b0;
        send(rep6(8'h00, 8'h05, 0, 0, 0, 0, 0));
        nv = 0;
        while (!cv && nv < 10) begin @(negedge clk); nv++; end
        chk("t6_pre_rst_valid", 32'(cv), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cvalid", 32'(cv), 32'd0);
        chk("t6_rst_ready", 32'(ready), 32'd1);
        chk("t6_rst_kmbyte", 32'(km_byte), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        char_ready = 1'b1;
        for (int s = 0; s < 6; s++) prev[s] = 8'h00;
        nv = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (cv) nv++; end
        chk("t6_no_reemit", 32'(nv), 32'd0);

        // random reports, follow-up variants, random sink back-pressure
        for (int it = 0; it < 25; it++) begin
            a = '0;
            a[7:0] = 8'($urandom);
            for (int s = 0; s < 6; s++) begin
                if ($urandom % 4 != 0) begin
                    c0 = 8'($urandom_range(4, 8'h28));
                    a[16+8*s +: 8] = (c0 == 8'h28) ? 8'h3A : c0;
                end
            end
            run(a, 1'b1, "rnd_a");
            b = a;
            b[7:0] = 8'($urandom);
            for (int s = 0; s < 6; s++) begin
                if ($urandom % 2 != 0) begin
                    c0 = 8'($urandom_range(0, 8'h28));
                    b[16+8*s +: 8] = (c0 == 8'h28) ? 8'h3A : (c0 < 8'h04 ? 8'h00 : c0);
                end
            end
            run(b, 1'b1, "rnd_b");
            run(64'h0, 1'b1, "rnd_rel");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
